// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 constants, widths, state type and round functions
package sha256_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BLOCK_W = 512;
  localparam int unsigned WIN_LEN = BLOCK_W / WORD_W;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } sched_state_e;

  localparam logic [31:0] H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Rotate right; n is always a constant in 1..31 at the call sites.
  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  // Message-schedule small sigma functions.
  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Compression-round functions, kept here so both blocks share one definition.
  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_sched_word.sv
// rtl/sha256_sched_word.sv - combinational next schedule word W[t+16] from the window
module sha256_sched_word
  import sha256_pkg::*;
(
  input  logic [31:0] w_t,
  input  logic [31:0] w_t1,
  input  logic [31:0] w_t9,
  input  logic [31:0] w_t14,
  output logic [31:0] w_new
);

  // W[t+16] = sigma1(W[t+14]) + W[t+9] + sigma0(W[t+1]) + W[t], wrapping mod 2^32.
  always_comb begin
    w_new = sigma1(w_t14) + w_t9 + sigma0(w_t1) + w_t;
  end

endmodule

// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - streams W0..W(NUM_ROUNDS-1) from one 512-bit block
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 64
) (
  input  logic         sys_clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         abort,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_data,
  output logic [5:0]   w_index,
  output logic         w_last,
  output logic         busy
);

  localparam logic [5:0] LAST_T = 6'(NUM_ROUNDS - 1);

  sched_state_e state, state_nxt;
  logic [31:0]  window [WIN_LEN];
  logic [5:0]   t;
  logic [31:0]  w_new;
  logic         last_word;
  logic         load;
  logic         word_hs;
  logic         aborting;

  assign last_word = (t == LAST_T);
  assign load      = blk_valid && blk_ready;
  // Abort wins over a same-cycle handshake, so the word is not consumed.
  assign aborting  = (state == ST_STREAM) && abort;
  assign word_hs   = w_valid && w_ready && !abort;

  assign w_data  = window[0];
  assign w_index = t;
  assign w_last  = (state == ST_STREAM) && last_word;

  sha256_sched_word u_sched_word (
    .w_t   (window[0]),
    .w_t1  (window[1]),
    .w_t9  (window[9]),
    .w_t14 (window[14]),
    .w_new (w_new)
  );

  // State register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs; blk_ready stays low while reset is held.
  always_comb begin
    state_nxt = state;
    blk_ready = 1'b0;
    w_valid   = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        blk_ready = rst_n;
        if (blk_valid && rst_n) state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        w_valid = 1'b1;
        busy    = 1'b1;
        if (abort)                       state_nxt = ST_IDLE;
        else if (w_ready && last_word)   state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Sliding 16-word window and round counter.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN_LEN; i++) window[i] <= '0;
      t <= '0;
    end else if (load) begin
      for (int i = 0; i < WIN_LEN; i++) window[i] <= blk_data[BLOCK_W-1-WORD_W*i -: WORD_W];
      t <= '0;
    end else if (aborting) begin
      t <= '0;
    end else if (word_hs) begin
      for (int i = 0; i < WIN_LEN - 1; i++) window[i] <= window[i+1];
      window[WIN_LEN-1] <= w_new;
      t <= last_word ? 6'd0 : t + 6'd1;
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb/tb_sha256_msg_schedule.sv - directed self-checking bench for sha256_msg_schedule
module tb_sha256_msg_schedule;

    logic         sys_clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         blk_valid = 1'b0;
    logic         blk_ready;
    logic [511:0] blk_data = '0;
    logic         abort = 1'b0;
    logic         w_valid;
    logic         w_ready = 1'b0;
    logic [31:0]  w_data;
    logic [5:0]   w_index;
    logic         w_last;
    logic         busy;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0]  gold [64];
    logic [31:0]  got [64];
    logic [511:0] blk_abc;
    logic [511:0] blk_ones;
    logic [511:0] blk_b;

    always #5 sys_clk = ~sys_clk;

    sha256_msg_schedule #(.NUM_ROUNDS(64)) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .abort     (abort),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_index   (w_index),
        .w_last    (w_last),
        .busy      (busy)
    );

    function automatic logic [31:0] tb_s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
    endfunction

    function automatic logic [31:0] tb_s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    task automatic compute_gold(input logic [511:0] b);
        for (int i = 0; i < 16; i++) gold[i] = b[511-32*i -: 32];
        for (int i = 16; i < 64; i++)
            gold[i] = tb_s1(gold[i-2]) + gold[i-7] + tb_s0(gold[i-15]) + gold[i-16];
    endtask

    task automatic load_block(input logic [511:0] b, output bit ok);
        int cnt;
        @(negedge sys_clk);
        blk_valid = 1'b1;
        blk_data  = b;
        cnt = 0;
        while (!blk_ready && cnt < 50) begin
            @(negedge sys_clk);
            cnt++;
        end
        ok = blk_ready;
        @(negedge sys_clk);
        blk_valid = 1'b0;
    endtask

    task automatic run_block(input logic [511:0] b, input string tag);
        bit ok;
        compute_gold(b);
        w_ready = 1'b1;
        load_block(b, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_load: blk_ready=%b, want 1", tag, blk_ready);
        end
        for (int i = 0; i < 64; i++) begin
            got[i] = w_data;
            n_checks++;
            if (w_valid !== 1'b1 || w_index !== 6'(i) || w_data !== gold[i] || w_last !== (i == 63)) begin
                n_fail++;
                $display("FAIL %s_word%0d: got valid=%b idx=%0d data=%h last=%b, want valid=1 idx=%0d data=%h last=%b",
                         tag, i, w_valid, w_index, w_data, w_last, i, gold[i], (i == 63));
            end
            @(negedge sys_clk);
        end
        n_checks++;
        if (w_valid !== 1'b0 || blk_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_end_idle: got valid=%b ready=%b busy=%b, want 0 1 0", tag, w_valid, blk_ready, busy);
        end
        w_ready = 1'b0;
    endtask

    task automatic test_reset;
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (w_valid !== 1'b0 || busy !== 1'b0 || w_last !== 1'b0 || blk_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got valid=%b busy=%b last=%b ready=%b, want 0 0 0 0",
                     w_valid, busy, w_last, blk_ready);
        end
        n_checks++;
        if (w_data !== 32'h0 || w_index !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_data: got data=%h idx=%0d, want 0 0", w_data, w_index);
        end
        repeat (3) @(negedge sys_clk);
        n_checks++;
        if (blk_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold_ready: got %b, want 0", blk_ready);
        end
        rst_n = 1'b1;
        @(negedge sys_clk);
        n_checks++;
        if (blk_ready !== 1'b1 || w_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got ready=%b valid=%b busy=%b, want 1 0 0", blk_ready, w_valid, busy);
        end
    endtask

    task automatic test_abc;
        run_block(blk_abc, "abc");
        n_checks++;
        if (got[0] !== 32'h61626380) begin
            n_fail++;
            $display("FAIL abc_w0: got %h, want 61626380", got[0]);
        end
        n_checks++;
        if (got[15] !== 32'h00000018) begin
            n_fail++;
            $display("FAIL abc_w15: got %h, want 00000018", got[15]);
        end
        n_checks++;
        if (got[16] !== 32'h61626380) begin
            n_fail++;
            $display("FAIL abc_w16: got %h, want 61626380", got[16]);
        end
        n_checks++;
        if (got[17] !== 32'h000F0000) begin
            n_fail++;
            $display("FAIL abc_w17: got %h, want 000f0000", got[17]);
        end
        n_checks++;
        if (got[18] !== 32'h7DA86405) begin
            n_fail++;
            $display("FAIL abc_w18: got %h, want 7da86405", got[18]);
        end
    endtask

    task automatic test_stall;
        bit ok;
        bit prev_stall;
        logic [31:0] pd;
        logic [5:0] pi;
        int idx;
        int cyc;
        compute_gold(blk_abc);
        w_ready = 1'b0;
        load_block(blk_abc, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL stall_load: blk_ready=%b, want 1", blk_ready);
        end
        idx = 0;
        cyc = 0;
        prev_stall = 1'b0;
        pd = '0;
        pi = '0;
        while (idx < 64 && cyc < 2000) begin
            n_checks++;
            if (w_valid !== 1'b1 || w_index !== 6'(idx) || w_data !== gold[idx] || w_last !== (idx == 63)) begin
                n_fail++;
                $display("FAIL stall_word%0d: got valid=%b idx=%0d data=%h last=%b, want valid=1 idx=%0d data=%h",
                         idx, w_valid, w_index, w_data, w_last, idx, gold[idx]);
            end
            if (prev_stall) begin
                n_checks++;
                if (w_data !== pd || w_index !== pi) begin
                    n_fail++;
                    $display("FAIL stall_stable: got data=%h idx=%0d, want data=%h idx=%0d", w_data, w_index, pd, pi);
                end
            end
            w_ready = 1'($urandom_range(0, 1));
            prev_stall = !w_ready;
            pd = w_data;
            pi = w_index;
            if (w_ready) idx++;
            @(negedge sys_clk);
            cyc++;
        end
        n_checks++;
        if (idx != 64) begin
            n_fail++;
            $display("FAIL stall_timeout: got %0d words, want 64", idx);
        end
        n_checks++;
        if (w_valid !== 1'b0 || blk_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_end_idle: got valid=%b ready=%b, want 0 1", w_valid, blk_ready);
        end
        w_ready = 1'b0;
    endtask

    task automatic test_all_ones;
        run_block(blk_ones, "ones");
    endtask

    task automatic test_back_to_back;
        compute_gold(blk_abc);
        w_ready = 1'b1;
        @(negedge sys_clk);
        n_checks++;
        if (blk_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready_start: got %b, want 1", blk_ready);
        end
        blk_valid = 1'b1;
        blk_data  = blk_abc;
        @(negedge sys_clk);
        blk_data = blk_b;
        for (int i = 0; i < 64; i++) begin
            n_checks++;
            if (w_valid !== 1'b1 || w_index !== 6'(i) || w_data !== gold[i] || w_last !== (i == 63)) begin
                n_fail++;
                $display("FAIL b2b_a_word%0d: got valid=%b idx=%0d data=%h last=%b, want idx=%0d data=%h",
                         i, w_valid, w_index, w_data, w_last, i, gold[i]);
            end
            if (i == 10) begin
                n_checks++;
                if (blk_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_ready_in_stream: got %b, want 0", blk_ready);
                end
            end
            @(negedge sys_clk);
        end
        n_checks++;
        if (w_valid !== 1'b0 || blk_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_bubble: got valid=%b ready=%b, want 0 1", w_valid, blk_ready);
        end
        @(negedge sys_clk);
        blk_valid = 1'b0;
        n_checks++;
        if (w_valid !== 1'b1 || w_index !== 6'd0 || w_data !== blk_b[511:480]) begin
            n_fail++;
            $display("FAIL b2b_second_w0: got valid=%b idx=%0d data=%h, want 1 0 %h",
                     w_valid, w_index, w_data, blk_b[511:480]);
        end
        compute_gold(blk_b);
        for (int i = 0; i < 64; i++) begin
            n_checks++;
            if (w_valid !== 1'b1 || w_index !== 6'(i) || w_data !== gold[i] || w_last !== (i == 63)) begin
                n_fail++;
                $display("FAIL b2b_b_word%0d: got valid=%b idx=%0d data=%h last=%b, want idx=%0d data=%h",
                         i, w_valid, w_index, w_data, w_last, i, gold[i]);
            end
            @(negedge sys_clk);
        end
        n_checks++;
        if (w_valid !== 1'b0 || blk_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_end_idle: got valid=%b ready=%b, want 0 1", w_valid, blk_ready);
        end
        w_ready = 1'b0;
    endtask

    task automatic test_abort;
        bit ok;
        compute_gold(blk_abc);
        w_ready = 1'b1;
        load_block(blk_abc, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL abort_load: blk_ready=%b, want 1", blk_ready);
        end
        for (int i = 0; i <= 20; i++) begin
            n_checks++;
            if (w_valid !== 1'b1 || w_index !== 6'(i) || w_data !== gold[i]) begin
                n_fail++;
                $display("FAIL abort_word%0d: got valid=%b idx=%0d data=%h, want 1 %0d %h",
                         i, w_valid, w_index, w_data, i, gold[i]);
            end
            if (i == 20) abort = 1'b1;
            @(negedge sys_clk);
        end
        abort = 1'b0;
        n_checks++;
        if (w_valid !== 1'b0 || busy !== 1'b0 || blk_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_idle: got valid=%b busy=%b ready=%b, want 0 0 1", w_valid, busy, blk_ready);
        end
        run_block(blk_b, "after_abort");
    endtask

    task automatic test_reset_mid;
        bit ok;
        compute_gold(blk_abc);
        w_ready = 1'b1;
        load_block(blk_abc, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rmid_load: blk_ready=%b, want 1", blk_ready);
        end
        for (int i = 0; i < 37; i++) @(negedge sys_clk);
        n_checks++;
        if (w_valid !== 1'b1 || w_index !== 6'd37 || w_data !== gold[37]) begin
            n_fail++;
            $display("FAIL rmid_at37: got valid=%b idx=%0d data=%h, want 1 37 %h", w_valid, w_index, w_data, gold[37]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (w_valid !== 1'b0 || busy !== 1'b0 || w_last !== 1'b0 || w_index !== 6'd0) begin
            n_fail++;
            $display("FAIL rmid_async: got valid=%b busy=%b last=%b idx=%0d, want 0 0 0 0",
                     w_valid, busy, w_last, w_index);
        end
        @(negedge sys_clk);
        rst_n = 1'b1;
        w_ready = 1'b0;
        test_abc();
    endtask

    initial begin
        blk_abc  = {32'h61626380, 448'h0, 32'h00000018};
        blk_ones = {512{1'b1}};
        for (int i = 0; i < 16; i++)
            blk_b[511-32*i -: 32] = 32'h9E3779B9 ^ (32'h01010101 * 32'(i + 1));
        test_reset();
        test_abc();
        test_stall();
        test_all_ones();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
